// File: rtl/port_arbiter_pkg.sv
// Shared router constants: requester bit order, port count and grant watchdog limit.
// Imported by the output-port arbiter and the output controller.
package port_arbiter_pkg;

  localparam int ROUTER_N_REQ    = 5;
  localparam int ROUTER_WDOG_MAX = 3;

  typedef enum logic [2:0] {
    REQ_PE = 3'd0,
    REQ_S  = 3'd1,
    REQ_N  = 3'd2,
    REQ_E  = 3'd3,
    REQ_W  = 3'd4
  } req_idx_e;

  // Round-robin successor of a granted index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/port_arbiter_rr_pick.sv
// Round-robin pick: first set req bit at or above ptr, wrapping to bit 0.
// Purely combinational; returns a one-hot grant and its index.
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic          found;
    int            jj;
    logic [PW-1:0] j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    jj    = 0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      jj = int'(ptr) + i;
      if (jj >= N) jj = jj - N;
      j = jj[PW-1:0];
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Output-port arbiter with independent even/odd channels: comb one-hot grant, one grant
// outstanding per channel until its clear returns on the opposite polarity; watchdog + sticky err.
module port_arbiter
  import port_arbiter_pkg::*;
#(
  parameter int N_REQ    = ROUTER_N_REQ,
  parameter int WDOG_MAX = ROUTER_WDOG_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             polarity,
  input  logic [N_REQ-1:0] req,
  input  logic             out_empty,
  input  logic [N_REQ-1:0] clear_in,
  output logic [N_REQ-1:0] grant,
  output logic             busy_even,
  output logic             busy_odd,
  output logic             err
);

  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(WDOG_MAX + 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(WDOG_MAX);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_MAX - 1);

  logic [PW-1:0]    ptr_q   [2];
  logic [PW-1:0]    ptr_d   [2];
  logic [1:0]       pend_q, pend_d;
  logic [N_REQ-1:0] lastg_q [2];
  logic [N_REQ-1:0] lastg_d [2];
  logic [WW-1:0]    wd_q    [2];
  logic [WW-1:0]    wd_d    [2];
  logic             err_q, err_d;

  logic             cur, oth;
  logic [1:0]       ack;
  logic             grant_en;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;

  assign cur = polarity;
  assign oth = ~polarity;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q[cur]),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign grant_en  = reset && out_empty && !pend_q[cur] && (req != '0);
  assign grant     = grant_en ? pick_gnt : '0;
  assign busy_even = pend_q[0];
  assign busy_odd  = pend_q[1];
  assign err       = err_q;

  always_comb begin
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    lastg_d = lastg_q;
    wd_d    = wd_q;
    err_d   = err_q;
    ack     = '0;

    // A clear always answers the grant made on the previous (opposite) polarity.
    if (clear_in != '0) begin
      if (pend_q[oth] && (clear_in == lastg_q[oth])) begin
        ack[oth]    = 1'b1;
        pend_d[oth] = 1'b0;
        wd_d[oth]   = '0;
      end else begin
        err_d = 1'b1;
      end
    end

    for (int c = 0; c < 2; c++) begin
      if (pend_q[c] && !ack[c]) begin
        if (wd_q[c] != WD_MAX) wd_d[c] = wd_q[c] + WW'(1);
        if (wd_q[c] >= WD_LAST) err_d = 1'b1;
      end
    end

    if (grant_en) begin
      pend_d[cur]  = 1'b1;
      lastg_d[cur] = pick_gnt;
      wd_d[cur]    = '0;
      ptr_d[cur]   = PW'(rr_next(int'(pick_idx), N_REQ));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q   <= '{default: '0};
      pend_q  <= '0;
      lastg_q <= '{default: '0};
      wd_q    <= '{default: '0};
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      lastg_q <= lastg_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: directed vector table, then random traffic against a reference model.
module tb_port_arbiter;

  localparam int N    = 5;
  localparam int WDOG = 3;

  logic       clk = 1'b0;
  logic       reset, polarity, out_empty;
  logic [4:0] req, clear_in, grant;
  logic       busy_even, busy_odd, err;

  port_arbiter #(.N_REQ(N), .WDOG_MAX(WDOG)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .req       (req),
    .out_empty (out_empty),
    .clear_in  (clear_in),
    .grant     (grant),
    .busy_even (busy_even),
    .busy_odd  (busy_odd),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         pol;
    logic [4:0] rq;
    bit         oe;
    logic [4:0] clr;
    logic [4:0] g;
    bit         be;
    bit         bo;
    bit         er;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state, one entry per channel (0 even, 1 odd).
  int         m_ptr   [2];
  bit         m_pend  [2];
  logic [4:0] m_lastg [2];
  int         m_wd    [2];
  bit         m_err;

  task automatic add(bit rst, bit pol, logic [4:0] rq, bit oe, logic [4:0] clr,
                     logic [4:0] g, bit be, bit bo, bit er);
    vec_t v;
    v.rst = rst; v.pol = pol; v.rq = rq; v.oe = oe; v.clr = clr;
    v.g = g; v.be = be; v.bo = bo; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(bit rst, bit pol, logic [4:0] rq, bit oe, logic [4:0] clr);
    reset = rst; polarity = pol; req = rq; out_empty = oe; clear_in = clr;
  endtask

  function automatic logic [4:0] m_grant(bit rst, bit pol, logic [4:0] rq, bit oe);
    int p;
    if (!rst || !oe || m_pend[pol] || rq == 5'd0) return 5'd0;
    for (int i = 0; i < N; i++) begin
      p = (m_ptr[pol] + i) % N;
      if (rq[p]) return 5'd1 << p;
    end
    return 5'd0;
  endfunction

  task automatic model_step(bit rst, bit pol, logic [4:0] rq, bit oe, logic [4:0] clr);
    logic [4:0] g;
    bit         acked [2];
    int         op;
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        m_ptr[c] = 0; m_pend[c] = 0; m_lastg[c] = 0; m_wd[c] = 0;
      end
      m_err = 0;
      return;
    end
    g  = m_grant(rst, pol, rq, oe);
    op = pol ? 0 : 1;
    acked[0] = 0;
    acked[1] = 0;
    if (clr != 5'd0) begin
      if (m_pend[op] && clr == m_lastg[op]) acked[op] = 1;
      else m_err = 1;
    end
    for (int c = 0; c < 2; c++) begin
      if (m_pend[c] && !acked[c]) begin
        m_wd[c] = m_wd[c] + 1;
        if (m_wd[c] >= WDOG) m_err = 1;
      end
      if (acked[c]) begin
        m_pend[c] = 0;
        m_wd[c]   = 0;
      end
    end
    if (g != 5'd0) begin
      for (int k = 0; k < N; k++)
        if (g[k]) m_ptr[pol] = (k + 1) % N;
      m_pend[pol]  = 1;
      m_lastg[pol] = g;
      m_wd[pol]    = 0;
    end
  endtask

  initial begin
    bit         pol;
    bit         rst;
    logic [4:0] rq, clr, eg;
    bit         oe;
    int         r;

    apply(0, 0, 5'd0, 1, 5'd0);

    //   rst pol req       oe clr       grant     be bo er
    add(0, 0, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0, 0); // held in reset
    add(0, 1, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0, 0);
    add(1, 0, 5'b11111, 1, 5'b00000, 5'b00001, 0, 0, 0); // fairness sweep
    add(1, 1, 5'b11111, 1, 5'b00001, 5'b00001, 1, 0, 0);
    add(1, 0, 5'b11111, 1, 5'b00001, 5'b00010, 0, 1, 0);
    add(1, 1, 5'b11111, 1, 5'b00010, 5'b00010, 1, 0, 0);
    add(1, 0, 5'b11111, 1, 5'b00010, 5'b00100, 0, 1, 0);
    add(1, 1, 5'b11111, 1, 5'b00100, 5'b00100, 1, 0, 0);
    add(1, 0, 5'b11111, 1, 5'b00100, 5'b01000, 0, 1, 0);
    add(1, 1, 5'b11111, 1, 5'b01000, 5'b01000, 1, 0, 0); // ack even + odd grant 01000
    add(1, 0, 5'b11111, 1, 5'b01000, 5'b10000, 0, 1, 0);
    add(1, 1, 5'b11111, 1, 5'b10000, 5'b10000, 1, 0, 0);
    add(1, 0, 5'b11111, 1, 5'b10000, 5'b00001, 0, 1, 0);
    add(1, 1, 5'b00000, 1, 5'b00001, 5'b00000, 1, 0, 0);
    add(1, 0, 5'b01000, 1, 5'b00000, 5'b01000, 0, 0, 0); // even ptr -> 4
    add(1, 1, 5'b00000, 1, 5'b01000, 5'b00000, 1, 0, 0);
    add(1, 0, 5'b00011, 1, 5'b00000, 5'b00001, 0, 0, 0); // wrap 4 -> 0
    add(1, 1, 5'b00000, 1, 5'b00001, 5'b00000, 1, 0, 0);
    add(1, 0, 5'b00011, 1, 5'b00000, 5'b00010, 0, 0, 0); // ptr became 1
    add(1, 1, 5'b00000, 1, 5'b00010, 5'b00000, 1, 0, 0);
    add(1, 0, 5'b00100, 0, 5'b00000, 5'b00000, 0, 0, 0); // blocked
    add(1, 1, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 0);
    add(1, 0, 5'b00101, 1, 5'b00000, 5'b00100, 0, 0, 0); // ptr held at 2
    add(1, 1, 5'b00000, 1, 5'b00100, 5'b00000, 1, 0, 0);
    add(1, 0, 5'b00010, 1, 5'b00000, 5'b00010, 0, 0, 0);
    add(1, 1, 5'b00000, 1, 5'b00100, 5'b00000, 1, 0, 0); // wrong clear
    add(1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 1, 0, 1);
    add(0, 1, 5'b00000, 1, 5'b00000, 5'b00000, 1, 0, 1);
    add(1, 0, 5'b00001, 1, 5'b00000, 5'b00001, 0, 0, 0); // watchdog run
    add(1, 1, 5'b00000, 1, 5'b00000, 5'b00000, 1, 0, 0);
    add(1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 1, 0, 0);
    add(1, 1, 5'b00000, 1, 5'b00000, 5'b00000, 1, 0, 0);
    add(1, 0, 5'b00000, 1, 5'b00000, 5'b00000, 1, 0, 1);
    add(1, 1, 5'b00000, 1, 5'b00001, 5'b00000, 1, 0, 1); // late ack, err stays
    add(1, 0, 5'b11111, 1, 5'b00000, 5'b00010, 0, 0, 1);
    add(0, 1, 5'b11111, 1, 5'b00000, 5'b00000, 1, 0, 1); // reset mid-transfer
    add(1, 0, 5'b00000, 1, 5'b00001, 5'b00000, 0, 0, 0); // stray clear after reset
    add(1, 1, 5'b00000, 1, 5'b00000, 5'b00000, 0, 0, 1);

    @(posedge clk); #1;
    for (int w = 0; w < 2; w++) begin
      apply(0, w[0], 5'd0, 1, 5'd0);
      model_step(0, w[0], 5'd0, 1, 5'd0);
      @(posedge clk); #1;
    end

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].pol, tbl[i].rq, tbl[i].oe, tbl[i].clr);
      @(negedge clk);
      chk("vec_grant", i, 32'(grant), 32'(tbl[i].g));
      chk("vec_busy_even", i, 32'(busy_even), 32'(tbl[i].be));
      chk("vec_busy_odd", i, 32'(busy_odd), 32'(tbl[i].bo));
      chk("vec_err", i, 32'(err), 32'(tbl[i].er));
      model_step(tbl[i].rst, tbl[i].pol, tbl[i].rq, tbl[i].oe, tbl[i].clr);
      @(posedge clk); #1;
    end

    pol = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      pol = ~pol;
      rst = ($urandom_range(0, 63) != 0);
      rq  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rq = 5'd0;
      oe  = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 19);
      if (r < 12 && m_pend[pol ? 0 : 1]) clr = m_lastg[pol ? 0 : 1];
      else if (r == 12) clr = 5'($urandom_range(1, 31));
      else clr = 5'd0;
      apply(rst, pol, rq, oe, clr);
      @(negedge clk);
      eg = m_grant(rst, pol, rq, oe);
      chk("rnd_grant", n, 32'(grant), 32'(eg));
      chk("rnd_busy_even", n, 32'(busy_even), 32'(m_pend[0]));
      chk("rnd_busy_odd", n, 32'(busy_odd), 32'(m_pend[1]));
      chk("rnd_err", n, 32'(err), 32'(m_err));
      model_step(rst, pol, rq, oe, clr);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have a parameter: N_REQ, default 5, number of requesters in bit order pe, s, n, e, w (bit 0 = pe).
REQ-002 SHALL have a parameter: WDOG_MAX, default 3, cycles a grant may remain unacknowledged before an error is flagged.
REQ-003 SHALL have the ports, one per line:
 clk  input  1  single clock, all state on rising edge.
 reset  input  1  synchronous, active-low (0 = reset).
 polarity  input  1  current channel (0 even, 1 odd); toggles every cycle, shared with the output controller.
 req  input  5  req[i] = requester i holds a packet for this output port in the channel selected by polarity.
 out_empty  input  1  output controller storage for the current polarity is empty.
 clear_in  input  5  one-hot acknowledge from the output controller (clear_pe..clear_w), 0 when idle.
 grant  output  5  one-hot grant to the output controller, 0 when no grant.
 busy_even  output  1  an even-channel grant is awaiting acknowledge.
 busy_odd  output  1  an odd-channel grant is awaiting acknowledge.
 err  output  1  sticky protocol-error flag.

Function
REQ-004 SHALL keep independent per-channel state for even and odd: round-robin pointer ptr (0..4), pending flag pend, last grant lastg (5 bits), watchdog counter wd (2 bits).
REQ-005 SHALL drive grant combinationally from registered state and inputs: nonzero only when reset=1, out_empty=1, pend[polarity]=0 and req!=0.
REQ-006 SHALL select the first set req bit searching upward from ptr[polarity], wrapping 4->0; grant SHALL be exactly one-hot.
REQ-007 SHALL, on a rising edge with grant!=0 at index k: set pend[polarity]=1, lastg[polarity]=grant, wd[polarity]=0, ptr[polarity]=(k+1) mod 5.
REQ-008 SHALL leave ptr unchanged for a channel in cycles without a grant on that channel.
REQ-009 SHALL treat clear_in!=0 as the acknowledge for channel !polarity (the output controller returns clear one cycle after grant, when polarity has flipped).
REQ-010 SHALL, when clear_in==lastg[!polarity] and pend[!polarity]=1, clear pend[!polarity] on that edge.
REQ-011 SHALL set err when clear_in!=0 and either pend[!polarity]=0 or clear_in!=lastg[!polarity]; pend state SHALL be unchanged in that case.
REQ-012 SHALL increment wd of each pending channel every cycle it is not acknowledged, and set err when wd reaches WDOG_MAX.
REQ-013 SHALL allow a grant and an acknowledge in the same cycle (different channels) with both updates applied.
REQ-014 SHALL drive busy_even=pend[0], busy_odd=pend[1].
REQ-015 SHALL hold err=1 until reset, regardless of later traffic.
REQ-016 SHALL take no action on req bits for a requester whose packet is not yet cleared; masking is via pend only (one outstanding grant per channel).

Reset
REQ-017 SHALL, while reset=0 at a rising edge, set ptr=0, pend=0, lastg=0, wd=0, err=0 for both channels.
REQ-018 SHALL force grant=0 whenever reset=0, including mid-transfer; a clear_in arriving the cycle after reset deasserts SHALL set err.

Structure
REQ-019 SHALL take N_REQ, the requester bit indices (PE=0, S=1, N=2, E=3, W=4) and WDOG_MAX defaults from the shared router package used by the output controller.
REQ-020 SHALL implement the round-robin pick as one sub-module rr_pick (inputs req, ptr; outputs one-hot grant, index), instantiated once and fed ptr[polarity].

Verification
REQ-021 Reset: reset=0 with req=5'b11111, out_empty=1 -> grant=0, busy_even=busy_odd=0, err=0.
REQ-022 Fairness: req=5'b11111, out_empty=1, clear_in returned correctly each cycle -> even grants 00001, 00010, 00100, 01000, 10000, 00001; odd channel rotates independently.
REQ-023 Wrap: ptr_even=4, req=5'b00011 -> grant 00001, ptr_even becomes 1.
REQ-024 Blocked: out_empty=0 with req=5'b00100 -> grant=0, ptr unchanged; out_empty=1 next even cycle -> grant=00100.
REQ-025 Bad acknowledge: even grant 00010, next cycle clear_in=00100 -> err=1, busy_even stays 1; watchdog with clear_in=0 for 3 cycles -> err=1.
REQ-026 Overlap: even pending acknowledge and odd grant 01000 issued in the same cycle -> busy_even=0, busy_odd=1 after the edge.
